// File: rtl/l2_mem_bank.sv
// Single-port 64-bit SRAM bank with byte enables, 1-cycle registered reads and a post-reset init sweep.
// Define L2_MEM_PARITY_EN to add per-byte even parity with error pulse, saturating count and first-error address.
module l2_mem_bank #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DEPTH      = 8192,
  parameter logic [63:0] INIT_VALUE = 64'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  csn_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            be_i,
  output logic [63:0]           rdata_o,
  output logic                  init_done_o,
  input  logic                  err_clr_i,
  output logic                  err_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             init_done_q, init_done_d;

  logic [63:0]      mem [DEPTH];
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_word;
  logic             rd_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_be;

  assign idx     = add_i[IDX_W-1:0];
  assign rd_word = mem[idx];

  // Only a partially populated address space needs a range check.
  generate
    if (DEPTH < 2**ADDR_WIDTH) begin : g_range
      localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
      assign in_range = (add_i < DEPTH_A);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rdata_d     = rdata_q;
    init_done_d = (state_q == ST_READY);
    mem_we      = 1'b0;
    mem_idx     = idx;
    mem_wdata   = wdata_i;
    mem_be      = be_i;
    rd_en       = 1'b0;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = init_cnt_q;
      mem_wdata = INIT_VALUE;
      mem_be    = 8'hFF;
      if (init_cnt_q == LAST_IDX) begin
        state_d = ST_READY;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end else if (!csn_i) begin
      if (!wen_i) begin
        mem_we = in_range;
      end else begin
        rd_en   = 1'b1;
        rdata_d = in_range ? rd_word : 64'h0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 8; k++) begin
      if (mem_we && mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  assign rdata_o     = rdata_q;
  assign init_done_o = init_done_q;

`ifdef L2_MEM_PARITY_EN
  logic [7:0]            par_mem [DEPTH];
  logic [7:0]            wpar;
  logic [7:0]            rpar;
  logic                  err_q, err_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_par
      assign wpar[gi] = ^mem_wdata[8*gi +: 8];
      assign rpar[gi] = ^rd_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 8; k++) begin
      if (mem_we && mem_be[k]) par_mem[mem_idx][k] <= wpar[k];
    end
  end

  // A clear in the same cycle as an error leaves that error as the first one recorded.
  always_comb begin
    err_d      = rd_en && in_range && (rpar != par_mem[idx]);
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_clr_i) begin
      err_cnt_d  = 16'h0;
      err_addr_d = '0;
    end
    if (err_d) begin
      if (err_clr_i || (err_cnt_q == 16'h0)) err_addr_d = add_i;
      if (err_clr_i)                    err_cnt_d = 16'h1;
      else if (err_cnt_q != 16'hFFFF)   err_cnt_d = err_cnt_q + 16'h1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      err_cnt_q  <= 16'h0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
  assign err_cnt_o      = 16'h0;
  assign err_addr_o     = '0;
`endif

endmodule
